// File: rtl/peripheral_ahb3_pkg.sv
// Shared AHB3-Lite encodings, slave FSM state type and byte-lane helper.
package peripheral_ahb3_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE  = 3'b000;
  localparam logic [2:0] HSIZE_HWORD = 3'b001;
  localparam logic [2:0] HSIZE_WORD  = 3'b010;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef logic [2:0] slv_state_t;

  localparam slv_state_t ST_IDLE = 3'd0;
  localparam slv_state_t ST_WAIT = 3'd1;
  localparam slv_state_t ST_DATA = 3'd2;
  localparam slv_state_t ST_ERR1 = 3'd3;
  localparam slv_state_t ST_ERR2 = 3'd4;

  // Little-endian lane enables; sizes above WORD are rejected before this is used.
  function automatic logic [3:0] ahb_byte_en(input logic [2:0] hsize, input logic [1:0] addr_lo);
    logic [3:0] be;
    case (hsize)
      HSIZE_BYTE:  be = 4'b0001 << addr_lo;
      HSIZE_HWORD: be = 4'b0011 << {addr_lo[1], 1'b0};
      default:     be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/peripheral_ahb3_slave_ram.sv
// Word-addressed 32-bit RAM: byte-enabled synchronous write, asynchronous read.
module peripheral_ahb3_slave_ram #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [3:0]    be_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/peripheral_ahb3_slave_mem.sv
// AHB3-Lite memory slave: programmable wait states, two-cycle ERROR for illegal transfers.
module peripheral_ahb3_slave_mem
  import peripheral_ahb3_pkg::*;
#(
  parameter int HADDR_SIZE  = 32,
  parameter int HDATA_SIZE  = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic                  HRESETn,
  input  logic                  HCLK,
  input  logic                  HSEL,
  input  logic [HADDR_SIZE-1:0] HADDR,
  input  logic [HDATA_SIZE-1:0] HWDATA,
  output logic [HDATA_SIZE-1:0] HRDATA,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [3:0]            HPROT,
  input  logic [1:0]            HTRANS,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic                  HRESP
);

  localparam int                    IDX_W     = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [HADDR_SIZE-1:0] BYTE_SPAN = HADDR_SIZE'(4 * MEM_DEPTH);
  localparam logic [3:0]            WS        = 4'(WAIT_STATES);

  slv_state_t       state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             write_q, write_d;
  logic [3:0]       be_q, be_d;

  logic        ready_int;
  logic        accept;
  logic        misalign;
  logic        illegal;
  logic        ram_we;
  logic [31:0] ram_rdata;
  logic        unused_ok;

  assign unused_ok = ^{HBURST, HPROT};

  // Gating with our own ready keeps a stray HREADY from restarting an open data phase.
  assign ready_int = (state_q != ST_WAIT) && (state_q != ST_ERR1);
  assign accept    = HSEL && HREADY && ready_int &&
                     ((HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ));

  assign misalign = ((HSIZE == HSIZE_HWORD) && HADDR[0]) ||
                    ((HSIZE == HSIZE_WORD) && (HADDR[1:0] != 2'b00));
  assign illegal  = (HADDR >= BYTE_SPAN) || (HSIZE > HSIZE_WORD) || misalign;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    write_d = write_q;
    be_d    = be_q;
    case (state_q)
      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = ST_DATA;
      end
      ST_ERR1: state_d = ST_ERR2;
      default: state_d = ST_IDLE;
    endcase
    if (accept) begin
      idx_d   = HADDR[IDX_W+1:2];
      write_d = HWRITE;
      be_d    = ahb_byte_en(HSIZE, HADDR[1:0]);
      if (illegal) begin
        state_d = ST_ERR1;
        cnt_d   = 4'd0;
      end else if (WS != 4'd0) begin
        state_d = ST_WAIT;
        cnt_d   = WS;
      end else begin
        state_d = ST_DATA;
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      write_q <= 1'b0;
      be_q    <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      write_q <= write_d;
      be_q    <= be_d;
    end
  end

  // Commit only on the final data-phase edge so a reset during waits drops the write.
  assign ram_we = (state_q == ST_DATA) && write_q;

  peripheral_ahb3_slave_ram #(
    .DEPTH (MEM_DEPTH),
    .AW    (IDX_W)
  ) u_ram (
    .clk_i   (HCLK),
    .we_i    (ram_we),
    .be_i    (be_q),
    .addr_i  (idx_q),
    .wdata_i (HWDATA),
    .rdata_o (ram_rdata)
  );

  assign HREADYOUT = ready_int;
  assign HRESP     = ((state_q == ST_ERR1) || (state_q == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
  assign HRDATA    = ((state_q == ST_DATA) && !write_q) ? ram_rdata : '0;

endmodule

// File: tb/tb_peripheral_ahb3_slave_mem.sv
// Scoreboard bench: two slaves (0 and 3 wait states) driven by a pipelined AHB master task.
module tb_peripheral_ahb3_slave_mem;
  import peripheral_ahb3_pkg::*;

  localparam int DEPTH = 256;

  logic        hclk = 1'b0;
  logic        hresetn;
  logic        hsel, hwrite;
  logic [31:0] haddr, hwdata;
  logic [2:0]  hsize, hburst;
  logic [3:0]  hprot;
  logic [1:0]  htrans;
  int          sel;

  logic        hsel0, hsel3, rdy0, rdy3, resp0, resp3;
  logic [31:0] rdata0, rdata3;
  logic        rdy, resp;
  logic [31:0] rdata;

  always #5 hclk = ~hclk;

  assign hsel0 = hsel && (sel == 0);
  assign hsel3 = hsel && (sel == 3);
  assign rdy   = (sel == 0) ? rdy0 : rdy3;
  assign resp  = (sel == 0) ? resp0 : resp3;
  assign rdata = (sel == 0) ? rdata0 : rdata3;

  peripheral_ahb3_slave_mem #(.HADDR_SIZE(32), .HDATA_SIZE(32), .MEM_DEPTH(DEPTH), .WAIT_STATES(0)) u_dut0 (
    .HRESETn(hresetn), .HCLK(hclk), .HSEL(hsel0), .HADDR(haddr), .HWDATA(hwdata),
    .HRDATA(rdata0), .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot),
    .HTRANS(htrans), .HREADY(rdy0), .HREADYOUT(rdy0), .HRESP(resp0)
  );

  peripheral_ahb3_slave_mem #(.HADDR_SIZE(32), .HDATA_SIZE(32), .MEM_DEPTH(DEPTH), .WAIT_STATES(3)) u_dut3 (
    .HRESETn(hresetn), .HCLK(hclk), .HSEL(hsel3), .HADDR(haddr), .HWDATA(hwdata),
    .HRDATA(rdata3), .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot),
    .HTRANS(htrans), .HREADY(rdy3), .HREADYOUT(rdy3), .HRESP(resp3)
  );

  typedef struct {
    logic        rd;
    logic        err;
    logic [31:0] data;
    int          waits;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] mdl [int];
  int          n_chk = 0;
  int          n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic int mkey(input logic [31:0] a);
    return sel * 65536 + int'(a >> 2);
  endfunction

  function automatic logic exp_illegal(input logic [2:0] size, input logic [31:0] addr);
    return (addr >= 32'(4 * DEPTH)) || (size > 3'd2) ||
           ((size == 3'd1) && addr[0]) || ((size == 3'd2) && (addr[1:0] != 2'b00));
  endfunction

  function automatic logic lane_hit(input logic [2:0] size, input logic [31:0] addr, input int b);
    int nb, lo;
    nb = 1 << size;
    lo = (int'(addr[1:0]) / nb) * nb;
    return (b >= lo) && (b < lo + nb);
  endfunction

  // Drives one address phase, pushes its expectation and returns just after the accept edge.
  task automatic ahb_xfer(input logic wr, input logic [2:0] size, input logic [31:0] addr,
                          input logic [31:0] wval, input logic [1:0] trans);
    exp_t        e;
    logic        ok;
    logic [31:0] w;
    int          key;
    e.rd    = !wr;
    e.err   = exp_illegal(size, addr);
    e.waits = e.err ? 1 : ((sel == 0) ? 0 : 3);
    e.data  = 32'h0;
    key     = mkey(addr);
    if (!e.err) begin
      if (wr) begin
        w = mdl.exists(key) ? mdl[key] : 32'h0;
        for (int b = 0; b < 4; b++) begin
          if (lane_hit(size, addr, b)) w[8*b +: 8] = wval[8*b +: 8];
        end
        mdl[key] = w;
      end else begin
        e.data = mdl.exists(key) ? mdl[key] : 32'h0;
      end
    end
    exp_q.push_back(e);
    hsel = 1'b1; haddr = addr; hwrite = wr; hsize = size; htrans = trans;
    hburst = 3'b001; hprot = 4'b0011;
    ok = 1'b0;
    for (int n = 0; n < 64 && !ok; n++) begin
      @(negedge hclk);
      ok = rdy;
      @(posedge hclk);
      #1;
    end
    if (!ok) check_eq("accept_timeout", 32'd0, 32'd1);
    hwdata = wr ? wval : 32'h0;
  endtask

  task automatic ahb_idle(input int n);
    hsel = 1'b0;
    htrans = HTRANS_IDLE;
    repeat (n) begin
      @(posedge hclk);
      #1;
    end
  endtask

  logic in_dp = 1'b0;
  int   wcnt = 0;

  always @(negedge hclk) begin
    exp_t e;
    logic err_e;
    if (!hresetn) begin
      in_dp = 1'b0;
      wcnt  = 0;
      exp_q.delete();
    end else begin
      if (in_dp && !rdy) begin
        wcnt++;
        err_e = (exp_q.size() > 0) ? exp_q[0].err : 1'b0;
        check_eq("wait_resp", 32'(resp), 32'(err_e));
        check_eq("wait_rdata", rdata, 32'h0);
      end else if (in_dp) begin
        if (exp_q.size() == 0) begin
          check_eq("sb_underflow", 32'd0, 32'd1);
        end else begin
          e = exp_q.pop_front();
          check_eq("waits", wcnt, e.waits);
          check_eq("resp", 32'(resp), 32'(e.err));
          check_eq("rdata", rdata, (e.rd && !e.err) ? e.data : 32'h0);
        end
      end else begin
        check_eq("idle_rdy", 32'(rdy), 32'd1);
        check_eq("idle_resp", 32'(resp), 32'd0);
        check_eq("idle_rdata", rdata, 32'h0);
      end
      if (!(in_dp && !rdy)) begin
        in_dp = hsel && htrans[1] && rdy;
        wcnt  = 0;
      end
    end
  end

  initial begin
    sel = 0; hsel = 1'b0; haddr = 32'h0; hwdata = 32'h0; hwrite = 1'b0;
    hsize = 3'd0; hburst = 3'd0; hprot = 4'd0; htrans = HTRANS_IDLE;
    hresetn = 1'b0;
    repeat (2) @(posedge hclk);
    #1;
    check_eq("rst_rdy0", 32'(rdy0), 32'd1);
    check_eq("rst_resp0", 32'(resp0), 32'd0);
    check_eq("rst_rdata0", rdata0, 32'h0);
    check_eq("rst_rdy3", 32'(rdy3), 32'd1);
    check_eq("rst_resp3", 32'(resp3), 32'd0);
    check_eq("rst_rdata3", rdata3, 32'h0);
    hresetn = 1'b1;
    @(posedge hclk);
    #1;

    // Zero wait states: word, byte and halfword lanes, pipelined read-after-write.
    ahb_xfer(1'b1, HSIZE_WORD, 32'h10, 32'hDEADBEEF, HTRANS_NONSEQ);
    ahb_xfer(1'b0, HSIZE_WORD, 32'h10, 32'h0, HTRANS_NONSEQ);
    ahb_xfer(1'b1, HSIZE_BYTE, 32'h20, 32'h0000_0011, HTRANS_NONSEQ);
    ahb_xfer(1'b1, HSIZE_BYTE, 32'h21, 32'h0000_2200, HTRANS_SEQ);
    ahb_xfer(1'b1, HSIZE_BYTE, 32'h22, 32'h0033_0000, HTRANS_SEQ);
    ahb_xfer(1'b1, HSIZE_BYTE, 32'h23, 32'h4400_0000, HTRANS_SEQ);
    ahb_xfer(1'b0, HSIZE_WORD, 32'h20, 32'h0, HTRANS_NONSEQ);
    ahb_xfer(1'b1, HSIZE_WORD, 32'h30, 32'h12345678, HTRANS_NONSEQ);
    ahb_xfer(1'b1, HSIZE_HWORD, 32'h32, 32'hABCD_0000, HTRANS_NONSEQ);
    ahb_xfer(1'b0, HSIZE_WORD, 32'h30, 32'h0, HTRANS_NONSEQ);
    ahb_idle(2);

    hsel = 1'b1; htrans = HTRANS_BUSY; haddr = 32'h30;
    @(posedge hclk);
    #1;
    ahb_idle(1);

    // Illegal transfers, then confirm the targeted words are untouched.
    ahb_xfer(1'b1, HSIZE_WORD, 32'h00, 32'h5A5A5A5A, HTRANS_NONSEQ);
    ahb_xfer(1'b1, HSIZE_WORD, 32'h02, 32'hFFFFFFFF, HTRANS_NONSEQ);
    ahb_xfer(1'b0, HSIZE_WORD, 32'h02, 32'h0, HTRANS_NONSEQ);
    ahb_xfer(1'b0, HSIZE_WORD, 32'h00, 32'h0, HTRANS_NONSEQ);
    ahb_xfer(1'b0, HSIZE_WORD, 32'(4 * DEPTH), 32'h0, HTRANS_NONSEQ);
    ahb_xfer(1'b1, 3'd3, 32'h40, 32'hFFFFFFFF, HTRANS_NONSEQ);
    ahb_xfer(1'b1, HSIZE_HWORD, 32'h31, 32'hFFFFFFFF, HTRANS_NONSEQ);
    ahb_xfer(1'b0, HSIZE_WORD, 32'h30, 32'h0, HTRANS_NONSEQ);
    ahb_xfer(1'b1, HSIZE_WORD, 32'(4 * DEPTH - 4), 32'hC0FFEE11, HTRANS_NONSEQ);
    ahb_xfer(1'b0, HSIZE_WORD, 32'(4 * DEPTH - 4), 32'h0, HTRANS_NONSEQ);
    ahb_idle(3);

    // Three wait states: pipelined write then SEQ read of the same word.
    sel = 3;
    ahb_idle(1);
    ahb_xfer(1'b1, HSIZE_WORD, 32'h40, 32'h600DCAFE, HTRANS_NONSEQ);
    ahb_xfer(1'b0, HSIZE_WORD, 32'h40, 32'h0, HTRANS_SEQ);
    ahb_xfer(1'b1, HSIZE_WORD, 32'h10, 32'h0BADF00D, HTRANS_NONSEQ);
    ahb_idle(6);

    // Reset during the wait cycles of a write must drop it.
    hsel = 1'b1; haddr = 32'h10; hwrite = 1'b1; hsize = HSIZE_WORD; htrans = HTRANS_NONSEQ;
    @(posedge hclk);
    #1;
    hsel = 1'b0; htrans = HTRANS_IDLE; hwdata = 32'hCAFEF00D;
    check_eq("abort_in_wait", 32'(rdy3), 32'd0);
    hresetn = 1'b0;
    #1;
    check_eq("abort_rdy", 32'(rdy3), 32'd1);
    check_eq("abort_resp", 32'(resp3), 32'd0);
    check_eq("abort_rdata", rdata3, 32'h0);
    repeat (2) @(posedge hclk);
    #1;
    hresetn = 1'b1;
    ahb_idle(1);
    ahb_xfer(1'b0, HSIZE_WORD, 32'h10, 32'h0, HTRANS_NONSEQ);
    ahb_idle(1);

    for (int n = 0; n < 50 && exp_q.size() > 0; n++) ahb_idle(1);
    ahb_idle(1);
    check_eq("sb_drain", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/peripheral_ahb3_slave_mem.md
# peripheral_ahb3_slave_mem

AHB3-Lite memory responder: a single-port slave that answers NONSEQ/SEQ transfers from the AHB3 bus-functional master with byte-lane-correct reads and writes to an internal word-addressed RAM. It supports a programmable number of wait states and gives the two-cycle ERROR response for illegal transfers. It is the target end of the AHB3 verification environment: the master BFM drives it, and scoreboards check it.

## Interface
- HADDR_SIZE, 32, address width
- HDATA_SIZE, 32, data width; only 32 is supported
- MEM_DEPTH, 256, RAM depth in 32-bit words (byte span = 4*MEM_DEPTH)
- WAIT_STATES, 0, number of HREADYOUT-low cycles inserted in every OKAY data phase (0..15)

Ports:
- HRESETn  in  1  asynchronous active-low reset
- HCLK  in  1  bus clock, rising edge
- HSEL  in  1  slave select
- HADDR  in  HADDR_SIZE  byte address
- HWDATA  in  HDATA_SIZE  write data, valid in data phase
- HRDATA  out  HDATA_SIZE  read data
- HWRITE  in  1  1 = write
- HSIZE  in  3  transfer size
- HBURST  in  3  burst type; accepted, not otherwise used
- HPROT  in  4  protection; accepted, ignored
- HTRANS  in  2  transfer type
- HREADY  in  1  bus-level ready; qualifies address phase
- HREADYOUT  out  1  slave ready
- HRESP  out  1  OKAY/ERROR

## Operation
- Accept condition: HSEL & HREADY & HTRANS ∈ {NONSEQ, SEQ} at a rising edge. On accept, latch HADDR, HWRITE and HSIZE. IDLE, BUSY or unselected cycles give a zero-wait OKAY.
- Error check at accept: word index ≥ MEM_DEPTH; HSIZE > WORD; misalignment (HWORD with HADDR[0]=1, WORD with HADDR[1:0]≠0). Any error starts the ERR sequence. No memory access takes place.
- Byte enables are little-endian:
  - BYTE: 4'b0001 << HADDR[1:0]
  - HWORD: 4'b0011 << {HADDR[1],1'b0}
  - WORD: 4'b1111
- Write: HWDATA lanes selected by the enables are committed at the edge that ends the data phase, which is the cycle where HREADYOUT=1. Unselected lanes are left unchanged.
- Read: HRDATA returns the full addressed word in the final data-phase cycle. All lanes are driven. HRDATA=0 in every other cycle.
- FSM states:
  - IDLE: no data phase.
  - WAIT: counter > 0, HREADYOUT=0, HRESP=OKAY.
  - DATA: HREADYOUT=1, OKAY.
  - ERR1: HREADYOUT=0, HRESP=ERROR.
  - ERR2: HREADYOUT=1, HRESP=ERROR.
- FSM transitions:
  - Accept and legal: go to WAIT if WAIT_STATES>0 (counter loaded with WAIT_STATES), else DATA.
  - Accept and illegal: go to ERR1, then ERR2.
  - From DATA or ERR2: a new accept in the same cycle (pipelined) goes straight to the next data phase; otherwise go to IDLE.
- Once a transfer is accepted, its data phase completes even if HSEL drops.

## Timing
- Reset values: HREADYOUT=1, HRESP=OKAY, HRDATA=0, FSM=IDLE, counter=0. RAM contents are not reset and are undefined.
- Data-phase length:
  - OKAY transfer: WAIT_STATES+1 cycles after the accept edge.
  - ERROR transfer: exactly 2 cycles.
- Back-to-back zero-wait transfers run at one transfer per cycle.
- Read-after-write to the same word in the next transfer returns the new data; no extra stall.
- Reset asserted mid-transfer aborts it. A write whose final data-phase edge has not occurred is not committed.
- While HREADYOUT=0, the slave's own HREADY input is low, so no new address phase is accepted.

## Structure
- Add to peripheral_ahb3_pkg:
  - byte-enable function (HSIZE, HADDR[1:0]) → 4-bit
  - FSM state typedef
- Existing HTRANS/HSIZE/HRESP constants are reused from peripheral_ahb3_pkg.
- One sub-module, peripheral_ahb3_slave_ram: byte-enabled synchronous write, asynchronous read, MEM_DEPTH×32.

## Test plan
- WAIT_STATES=0. WORD write of 0xDEADBEEF to 0x10, then WORD read of 0x10 → HRDATA=0xDEADBEEF one cycle after the read accept, HRESP=OKAY.
- BYTE writes of 0x11, 0x22, 0x33, 0x44 to 0x20..0x23, then WORD read of 0x20 → 0x44332211.
- HWORD write of 0xABCD to 0x32 over an existing word 0x12345678 at 0x30 → read returns 0xABCD5678.
- WORD read at 0x02 (misaligned) → ERR1 (HREADYOUT=0, HRESP=1), then ERR2 (HREADYOUT=1, HRESP=1). Memory is unchanged. The same check with address 4*MEM_DEPTH gives the same response.
- WAIT_STATES=3. Pipelined NONSEQ write followed by SEQ read → HREADYOUT low for 3 cycles on each transfer; the read returns the just-written data.
- Assert HRESETn during the WAIT cycle of a write → outputs return to reset values immediately. A subsequent read of that address shows the old contents.
